ram_stream_reader: RTL and testbench

Sequential read engine for one port of the team's true-dual-port block RAM. On a start pulse it reads `len` consecutive words from `base_addr`, wrapping modulo the RAM depth. It absorbs the RAM's one-cycle registered read latency and presents the words on a valid/ready stream with full back-pressure support. It drives the RAM address and the write enable (held low) and consumes the RAM data output. It is the consumer end of RAM contents preloaded from an init file or written by the other RAM port.

---
 rtl/ram_stream_reader.sv | 234 +++++++++++++++++++++++
 tb/tb_ram_stream_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ram_stream_reader
//
// Sequential read engine for one port of a true-dual-port block RAM with a
// one-cycle registered read. A start pulse reads `len` consecutive words
// from `base_addr` (wrapping modulo 2**ADDR_WIDTH). The words go out on a
// valid/ready stream through a 4-entry FIFO, with full back-pressure.
//
// Optional feature macro: RAM_READER_LAST_EN
//   When defined, adds the m_last output. m_last marks the beat carrying the
//   final word of the transfer and is stored per FIFO entry.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset; aborts any transfer
//   start      in   one-cycle request, sampled only while idle
//   base_addr  in   first word address, sampled with start
//   len        in   word count 0..2**ADDR_WIDTH, sampled with start
//   busy       out  high from the cycle after an accepted start until done
//   done       out  one-cycle pulse when the transfer has fully drained
//   ram_addr   out  registered RAM address
//   ram_wr_en  out  constant 0 (this port only reads)
//   ram_dout   in   RAM read data, valid one cycle after ram_addr
//   m_valid    out  stream data valid (FIFO non-empty)
//   m_ready    in   stream consumer ready
//   m_data     out  stream data (FIFO head)
//   m_last     out  final-beat marker (RAM_READER_LAST_EN only)
// ---------------------------------------------------------------------------
module ram_stream_reader #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef RAM_READER_LAST_EN
    ,
    output logic                  m_last
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam int FIFO_DEPTH = 4;

    state_t                  state;
    state_t                  state_next;

    logic [ADDR_WIDTH:0]     remaining;
    logic                    rd_pending;   // a read issued last cycle; its word is on ram_dout now
    logic [1:0]              inflight;
    logic [2:0]              fifo_count;
    logic [2:0]              credit_used;
    logic [1:0]              wr_ptr;
    logic [1:0]              rd_ptr;
    logic [DATA_WIDTH-1:0]   fifo_data [0:FIFO_DEPTH-1];

    logic                    issue;
    logic                    load;
    logic                    done_next;
    logic                    push;
    logic                    pop;
    logic                    last_issue;

    // ------------------------------------------------------------------
    // Credit accounting. A read issued in cycle c is sampled by the RAM at
    // the end of c and written into the FIFO at the end of c+1, so at most
    // one issued read is outstanding when a new one is considered. Keeping
    // FIFO occupancy plus outstanding reads below the FIFO depth means a
    // returning word always has a free slot, even with m_ready held low.
    // ------------------------------------------------------------------
    assign inflight    = {1'b0, rd_pending};
    assign credit_used = fifo_count + {1'b0, inflight};
    assign push        = rd_pending;
    assign pop         = m_valid && m_ready;
    assign last_issue  = issue && (remaining == (ADDR_WIDTH + 1)'(1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_next = state;
        issue      = 1'b0;
        load       = 1'b0;
        done_next  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        load       = 1'b1;
                        state_next = S_RUN;
                    end else begin
                        // Empty transfer: nothing to read, just report done.
                        state_next = S_DRAIN;
                    end
                end
            end

            S_RUN: begin
                if (credit_used < 3'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (remaining == (ADDR_WIDTH + 1)'(1)) begin
                        state_next = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                // Leave on the same edge that pops the final word, so done
                // appears in the cycle right after the last beat.
                if (!rd_pending &&
                    ((fifo_count == 3'd0) || ((fifo_count == 3'd1) && pop))) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address, counters and FIFO pointers
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr   <= '0;
            remaining  <= '0;
            rd_pending <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            done       <= 1'b0;
        end else begin
            if (load) begin
                ram_addr  <= base_addr;
                remaining <= len;
            end else if (issue) begin
                // Natural overflow of the address width gives the wrap to 0.
                ram_addr  <= ram_addr + ADDR_WIDTH'(1);
                remaining <= remaining - (ADDR_WIDTH + 1)'(1);
            end

            rd_pending <= issue;

            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            fifo_count <= fifo_count + {2'b00, push} - {2'b00, pop};

            done <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the data array has no reset; occupancy is tracked by the reset
    // pointers and count, and m_valid qualifies whatever the array holds.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= ram_dout;
        end
    end

`ifdef RAM_READER_LAST_EN
    logic rd_pending_last;
    logic fifo_last [0:FIFO_DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending_last <= 1'b0;
        end else begin
            rd_pending_last <= last_issue;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_last[wr_ptr] <= rd_pending_last;
        end
    end

    // Gated by m_valid so the unreset storage never leaks onto the port.
    assign m_last = m_valid && fifo_last[rd_ptr];
`else
    logic unused_last;
    assign unused_last = last_issue;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = (state != S_IDLE);
    assign m_valid   = (fifo_count != 3'd0);
    assign m_data    = fifo_data[rd_ptr];
    assign ram_wr_en = 1'b0;

endmodule

// File: tb/tb_ram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_stream_reader
//
// Directed bench for ram_stream_reader. A behavioural RAM with a one-cycle
// registered read is preloaded with word[i] = i. Inputs change on the
// falling edge; outputs are sampled on the falling edge, away from the
// rising edge where the design updates.
// With RAM_READER_LAST_EN defined the bench also checks m_last.
// ---------------------------------------------------------------------------
module tb_ram_stream_reader;

    localparam int DW    = 36;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr;
    logic          ram_wr_en;
    logic [DW-1:0] ram_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef RAM_READER_LAST_EN
    logic          m_last;
`endif

    int errors;
    int checks;

    logic [DW-1:0] mem [0:DEPTH-1];

    ram_stream_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_wr_en(ram_wr_en),
        .ram_dout (ram_dout),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data)
`ifdef RAM_READER_LAST_EN
        ,
        .m_last   (m_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM port: registered read, word[i] = i.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DW'(i);
        end
    end

    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one transfer starting at the current falling edge. bp selects the
    // ready pattern 1,0,0,1,0 repeating; poke fires a second start mid-run.
    task automatic run_stream(input string tag, input int base, input int n, input bit bp,
                              input bit poke, input int budget,
                              output int done_cyc, output int beats, output int ahead_max);
        logic [DW-1:0] prev_data;
        logic [AW-1:0] ahead;
        bit            prev_stall;
        int            ph;

        start      = 1'b1;
        base_addr  = AW'(base);
        len        = (AW + 1)'(n);
        done_cyc   = -1;
        beats      = 0;
        ahead_max  = 0;
        prev_stall = 1'b0;
        prev_data  = '0;

        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && c == 3) begin
                start     = 1'b1;
                base_addr = AW'(100);
                len       = (AW + 1)'(3);
            end

            if (prev_stall) begin
                check({tag, " hold_valid"}, 64'(m_valid), 64'd1);
                check({tag, " hold_data"}, 64'(m_data), 64'(prev_data));
            end

            if (bp && busy) begin
                ahead = ram_addr - AW'(base) - AW'(beats);
                if (int'(ahead) > ahead_max) ahead_max = int'(ahead);
            end

            if (done) begin
                done_cyc = c;
                check({tag, " idle_at_done"}, {62'd0, busy, m_valid}, 64'd0);
                break;
            end

            ph      = (c - 1) % 5;
            m_ready = bp ? ((ph == 0) || (ph == 3)) : 1'b1;

            if (m_valid && m_ready) begin
                check({tag, " data"}, 64'(m_data), 64'((base + beats) % DEPTH));
`ifdef RAM_READER_LAST_EN
                check({tag, " last"}, 64'(m_last), 64'(beats == n - 1));
`endif
                beats++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end

        start   = 1'b0;
        m_ready = 1'b1;
        check({tag, " done_seen"}, 64'(done_cyc > 0), 64'd1);
        check({tag, " beat_count"}, 64'(beats), 64'(n));
    endtask

    initial begin
        int  dc;
        int  nb;
        int  am;
        bit  stray;

        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        m_ready   = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst m_valid", 64'(m_valid), 64'd0);
        check("rst ram_addr", 64'(ram_addr), 64'd0);
        check("rst ram_wr_en", 64'(ram_wr_en), 64'd0);
`ifdef RAM_READER_LAST_EN
        check("rst m_last", 64'(m_last), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // ---- base=5 len=4, cycle-exact: beats in cycles 3..6, done in 7 ----
        start     = 1'b1;
        base_addr = AW'(5);
        len       = (AW + 1)'(4);
        m_ready   = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) begin
                check("t1 ram_addr_c1", 64'(ram_addr), 64'd5);
                check("t1 wr_en", 64'(ram_wr_en), 64'd0);
            end
            check($sformatf("t1 busy_c%0d", c), 64'(busy), 64'(c <= 6));
            check($sformatf("t1 done_c%0d", c), 64'(done), 64'(c == 7));
            check($sformatf("t1 valid_c%0d", c), 64'(m_valid), 64'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) begin
                check($sformatf("t1 data_c%0d", c), 64'(m_data), 64'(5 + c - 3));
`ifdef RAM_READER_LAST_EN
                check($sformatf("t1 last_c%0d", c), 64'(m_last), 64'(c == 6));
`endif
            end
        end

        // ---- wrap-around: 1022,1023,0,1 ----
        run_stream("wrap", 1022, 4, 1'b0, 1'b0, 40, dc, nb, am);
        check("wrap done_cycle", 64'(dc), 64'd7);

        // ---- back-pressure: ready 1,0,0,1,0,... ----
        run_stream("bp", 10, 8, 1'b1, 1'b0, 200, dc, nb, am);
        check("bp ahead_le4", 64'(am <= 4), 64'd1);

        // ---- len=0: busy in cycle 1 only, done in cycle 2, no beats ----
        start     = 1'b1;
        base_addr = AW'(3);
        len       = '0;
        @(negedge clk);
        start = 1'b0;
        check("len0 busy_c1", 64'(busy), 64'd1);
        check("len0 valid_c1", 64'(m_valid), 64'd0);
        check("len0 done_c1", 64'(done), 64'd0);
        @(negedge clk);
        check("len0 done_c2", 64'(done), 64'd1);
        check("len0 busy_c2", 64'(busy), 64'd0);
        check("len0 valid_c2", 64'(m_valid), 64'd0);
        @(negedge clk);
        check("len0 done_c3", 64'(done), 64'd0);

        // ---- len=1024: every address once, in order, full throughput ----
        run_stream("full", 700, 1024, 1'b0, 1'b0, 1100, dc, nb, am);
        check("full done_cycle", 64'(dc), 64'd1027);

        // ---- start pulsed during RUN is ignored ----
        run_stream("poke", 20, 6, 1'b0, 1'b1, 60, dc, nb, am);
        check("poke done_cycle", 64'(dc), 64'd9);
        stray = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy || m_valid) stray = 1'b1;
        end
        check("poke no_stray_activity", 64'(stray), 64'd0);

        // ---- async reset with 3 words buffered ----
        start     = 1'b1;
        base_addr = AW'(50);
        len       = (AW + 1)'(8);
        m_ready   = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("arst valid_before", 64'(m_valid), 64'd1);
        check("arst busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst m_valid", 64'(m_valid), 64'd0);
        check("arst busy", 64'(busy), 64'd0);
        check("arst done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        run_stream("post_rst", 0, 2, 1'b0, 1'b0, 30, dc, nb, am);
        check("post_rst done_cycle", 64'(dc), 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
